// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: client and server signals of bus_arbiter; timeout_err exists only with ARB_TIMEOUT_EN.
interface bus_arbiter_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4
);
  logic [NUM_CLIENTS-1:0]            rq;
  logic [NUM_CLIENTS-1:0]            ack;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_addr;
  logic [NUM_CLIENTS-1:0]            cl_wr_ni;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_dataW;
  logic [DATA_WIDTH-1:0]             cl_dataR;
  logic                              srv_req;
  logic [ADDR_WIDTH-1:0]             srv_addr;
  logic                              srv_wr_ni;
  logic [DATA_WIDTH-1:0]             srv_dataW;
  logic                              srv_ack;
  logic [DATA_WIDTH-1:0]             srv_dataR;
  logic [$clog2(NUM_CLIENTS)-1:0]    grant_id;
  logic                              busy;
`ifdef ARB_TIMEOUT_EN
  logic                              timeout_err;
  modport master (
    input  rq, cl_addr, cl_wr_ni, cl_dataW, srv_ack, srv_dataR,
    output ack, cl_dataR, srv_req, srv_addr, srv_wr_ni, srv_dataW, grant_id, busy, timeout_err
  );
  modport slave (
    output rq, cl_addr, cl_wr_ni, cl_dataW, srv_ack, srv_dataR,
    input  ack, cl_dataR, srv_req, srv_addr, srv_wr_ni, srv_dataW, grant_id, busy, timeout_err
  );
`else
  modport master (
    input  rq, cl_addr, cl_wr_ni, cl_dataW, srv_ack, srv_dataR,
    output ack, cl_dataR, srv_req, srv_addr, srv_wr_ni, srv_dataW, grant_id, busy
  );
  modport slave (
    output rq, cl_addr, cl_wr_ni, cl_dataW, srv_ack, srv_dataR,
    input  ack, cl_dataR, srv_req, srv_addr, srv_wr_ni, srv_dataW, grant_id, busy
  );
`endif
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin rq/ack arbiter sharing one server port among NUM_CLIENTS clients.
// Define ARB_TIMEOUT_EN to bound the server wait at TIMEOUT REQ cycles and add the timeout_err pulse.
module bus_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT   = 16
`endif
) (
  input logic           clk,
  input logic           reset,
  bus_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_CLIENTS);
  typedef enum logic [1:0] {IDLE, REQ, ACK, RELEASE} state_t;
  state_t                state, state_n;
  logic [IW-1:0]         ptr, gid, win;
  logic                  found, done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] dw_q, dr_q;
  function automatic logic [IW-1:0] wrap(input int j);
    return IW'(j >= NUM_CLIENTS ? j - NUM_CLIENTS : j);
  endfunction
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          tmo, to_q;
  assign tmo  = state == REQ && !bus.srv_ack && cnt == CW'(TIMEOUT - 1);
  assign done = state == REQ && (bus.srv_ack || tmo);
  assign bus.timeout_err = state == ACK && to_q;
`else
  assign done = state == REQ && bus.srv_ack;
`endif
  // Scanning downward lets the nearest requester at or after ptr win.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--)
      if (bus.rq[wrap(int'(ptr) + k)]) begin
        found = 1'b1;
        win   = wrap(int'(ptr) + k);
      end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (found) state_n = REQ;
      REQ:     if (done) state_n = ACK;
      ACK:     state_n = RELEASE;
      RELEASE: if (!bus.rq[gid]) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      gid    <= '0;
      addr_q <= '0;
      wr_q   <= 1'b0;
      dw_q   <= '0;
      dr_q   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && found) begin
        gid    <= win;
        addr_q <= bus.cl_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        wr_q   <= bus.cl_wr_ni[win];
        dw_q   <= bus.cl_dataW[win*DATA_WIDTH +: DATA_WIDTH];
      end
      if (done) dr_q <= bus.srv_ack ? bus.srv_dataR : '0;
      if (state == RELEASE && !bus.rq[gid]) ptr <= wrap(int'(gid) + 1);
    end
  end
`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      to_q <= 1'b0;
    end else begin
      cnt  <= state == REQ ? cnt + 1'b1 : '0;
      to_q <= tmo;
    end
  end
`endif
  assign bus.srv_req   = state == REQ;
  assign bus.busy      = state != IDLE;
  assign bus.ack       = state == ACK ? NUM_CLIENTS'(1) << gid : '0;
  assign bus.grant_id  = gid;
  assign bus.srv_addr  = addr_q;
  assign bus.srv_wr_ni = wr_q;
  assign bus.srv_dataW = dw_q;
  assign bus.cl_dataR  = dr_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter with modelled rq/ack clients and a server of programmable latency.
module tb_bus_arbiter;
  typedef struct {int id; logic [3:0] a; logic w; logic [7:0] d; int lat;} cmd_t;
  typedef struct {int id; logic [7:0] r; int gap; logic to;} ack_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int nvec = 0;
  int nerr = 0;
  int srv_lat = 1;
  int issued [4] = '{0, 0, 0, 0};
  int served [4] = '{0, 0, 0, 0};
  logic [7:0] mem [16];
  cmd_t cmd_q[$];
  ack_t ack_q[$];
  bus_arbiter_if #(.NUM_CLIENTS(4), .DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();
  bus_arbiter #(.NUM_CLIENTS(4), .DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic set_client(input int i, input logic [3:0] a, input logic w, input logic [7:0] d);
    bus.cl_addr[i*4 +: 4]  = a;
    bus.cl_wr_ni[i]        = w;
    bus.cl_dataW[i*8 +: 8] = d;
  endtask
  task automatic wait_idle(input int lim);
    int n = 0;
    do begin
      @(posedge clk); #3;
      n++;
    end while (n < lim && !(cmd_q.size() == 0 && ack_q.size() == 0 && !bus.busy && bus.rq == 4'b0));
    chk("idle wait", 32'(n < lim), 1);
    @(negedge clk);
  endtask
  // Clients hold rq until they see ack, drop it for a cycle, then re-request if more is pending.
  initial begin
    logic [3:0] a;
    logic [3:0] r;
    bus.rq = '0;
    forever begin
      @(negedge clk);
      a = bus.ack;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
        if (a[i]) begin
          served[i]++;
          r[i] = 1'b0;
        end else r[i] = issued[i] > served[i];
      bus.rq = r;
    end
  end
  initial begin
    int n = 0;
    bus.srv_ack   = 1'b0;
    bus.srv_dataR = '0;
    forever begin
      @(posedge clk); #1;
      n = bus.srv_req ? n + 1 : 0;
      bus.srv_ack   = bus.srv_req && n == srv_lat;
      bus.srv_dataR = bus.srv_ack ? mem[bus.srv_addr] : 8'hEE;
    end
  end
  initial begin
    cmd_t c;
    ack_t k;
    int len = 0;
    int cyc = 0;
    int last = 0;
    logic pr = 1'b0;
    logic pa = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.srv_req && !pr) begin
        if (cmd_q.size() == 0) chk("unexpected srv_req", 1, 0);
        else begin
          c = cmd_q.pop_front();
          chk("cmd grant_id", 32'(bus.grant_id), c.id);
          chk("cmd srv_addr", 32'(bus.srv_addr), 32'(c.a));
          chk("cmd srv_wr_ni", 32'(bus.srv_wr_ni), 32'(c.w));
          chk("cmd srv_dataW", 32'(bus.srv_dataW), 32'(c.d));
        end
        len = 1;
      end else if (bus.srv_req) begin
        len++;
        chk("srv_addr stable", 32'(bus.srv_addr), 32'(c.a));
        chk("srv_dataW stable", 32'(bus.srv_dataW), 32'(c.d));
      end else if (pr) chk("srv_req length", len, c.lat);
      if (bus.ack != 4'b0) begin
        chk("ack single cycle", 32'(pa), 0);
        if (ack_q.size() == 0) chk("unexpected ack", 32'(bus.ack), 0);
        else begin
          k = ack_q.pop_front();
          chk("ack onehot", 32'(bus.ack), 32'(1) << k.id);
          chk("ack cl_dataR", 32'(bus.cl_dataR), 32'(k.r));
          if (k.gap != 0) chk("ack spacing", cyc - last, k.gap);
`ifdef ARB_TIMEOUT_EN
          chk("timeout_err with ack", 32'(bus.timeout_err), 32'(k.to));
`endif
        end
        last = cyc;
      end
`ifdef ARB_TIMEOUT_EN
      else if (bus.timeout_err) chk("stray timeout_err", 1, 0);
`endif
      pr = bus.srv_req;
      pa = |bus.ack;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {4'hC, 4'(i)};
    mem[3] = 8'hA5;
    bus.cl_addr  = '0;
    bus.cl_wr_ni = '0;
    bus.cl_dataW = '0;
    repeat (2) @(negedge clk);
    chk("reset ack", 32'(bus.ack), 0);
    chk("reset srv_req", 32'(bus.srv_req), 0);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset grant_id", 32'(bus.grant_id), 0);
    chk("reset cl_dataR", 32'(bus.cl_dataR), 0);
    chk("reset srv_addr", 32'(bus.srv_addr), 0);
    chk("reset srv_dataW", 32'(bus.srv_dataW), 0);
    reset = 1'b0;
    // single read from client 0 with an immediate server response
    set_client(0, 4'h3, 1'b1, 8'h00);
    cmd_q.push_back('{0, 4'h3, 1'b1, 8'h00, 1});
    ack_q.push_back('{0, 8'hA5, 0, 1'b0});
    issued[0]++;
    @(negedge clk);
    chk("t1 srv_req c0", 32'(bus.srv_req), 0);
    chk("t1 busy c0", 32'(bus.busy), 0);
    @(negedge clk);
    chk("t1 srv_req c1", 32'(bus.srv_req), 1);
    chk("t1 srv_addr c1", 32'(bus.srv_addr), 3);
    chk("t1 srv_wr_ni c1", 32'(bus.srv_wr_ni), 1);
    @(negedge clk);
    chk("t1 ack c2", 32'(bus.ack), 1);
    chk("t1 cl_dataR c2", 32'(bus.cl_dataR), 32'hA5);
    @(negedge clk);
    chk("t1 busy c3", 32'(bus.busy), 1);
    @(negedge clk);
    chk("t1 busy c4", 32'(bus.busy), 0);
    // all four request at once, client 0 twice
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_client(0, 4'h4, 1'b0, 8'h10);
    set_client(1, 4'h5, 1'b1, 8'h21);
    set_client(2, 4'h6, 1'b0, 8'h32);
    set_client(3, 4'h7, 1'b1, 8'h43);
    cmd_q.push_back('{0, 4'h4, 1'b0, 8'h10, 1});
    cmd_q.push_back('{1, 4'h5, 1'b1, 8'h21, 1});
    cmd_q.push_back('{2, 4'h6, 1'b0, 8'h32, 1});
    cmd_q.push_back('{3, 4'h7, 1'b1, 8'h43, 1});
    cmd_q.push_back('{0, 4'h4, 1'b0, 8'h10, 1});
    ack_q.push_back('{0, 8'hC4, 0, 1'b0});
    ack_q.push_back('{1, 8'hC5, 4, 1'b0});
    ack_q.push_back('{2, 8'hC6, 4, 1'b0});
    ack_q.push_back('{3, 8'hC7, 4, 1'b0});
    ack_q.push_back('{0, 8'hC4, 4, 1'b0});
    issued[0] += 2;
    issued[1]++;
    issued[2]++;
    issued[3]++;
    wait_idle(100);
    // client 2 moves ptr to 3, then 0 and 2 together: 0 wins after the wrap
    set_client(2, 4'h8, 1'b1, 8'h66);
    set_client(0, 4'hA, 1'b0, 8'h77);
    cmd_q.push_back('{2, 4'h8, 1'b1, 8'h66, 1});
    ack_q.push_back('{2, 8'hC8, 0, 1'b0});
    issued[2]++;
    wait_idle(50);
    cmd_q.push_back('{0, 4'hA, 1'b0, 8'h77, 1});
    cmd_q.push_back('{2, 4'h8, 1'b1, 8'h66, 1});
    ack_q.push_back('{0, 8'hCA, 0, 1'b0});
    ack_q.push_back('{2, 8'hC8, 4, 1'b0});
    issued[0]++;
    issued[2]++;
    wait_idle(50);
    // slow server: five REQ cycles
    srv_lat = 5;
    set_client(1, 4'h9, 1'b0, 8'h5A);
    cmd_q.push_back('{1, 4'h9, 1'b0, 8'h5A, 5});
    ack_q.push_back('{1, 8'hC9, 0, 1'b0});
    issued[1]++;
    wait_idle(50);
    // reset in the third REQ cycle of client 3; afterwards client 1 goes first
    srv_lat = 100;
    set_client(1, 4'h1, 1'b1, 8'h11);
    set_client(3, 4'hE, 1'b0, 8'h33);
    cmd_q.push_back('{3, 4'hE, 1'b0, 8'h33, 3});
    cmd_q.push_back('{1, 4'h1, 1'b1, 8'h11, 1});
    cmd_q.push_back('{3, 4'hE, 1'b0, 8'h33, 1});
    ack_q.push_back('{1, 8'hC1, 0, 1'b0});
    ack_q.push_back('{3, 8'hCE, 4, 1'b0});
    issued[1]++;
    issued[3]++;
    begin
      int n = 0;
      while (!bus.srv_req && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("t5 srv_req seen", 32'(bus.srv_req), 1);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    srv_lat = 1;
    @(negedge clk);
    chk("t5 srv_req after reset", 32'(bus.srv_req), 0);
    chk("t5 ack after reset", 32'(bus.ack), 0);
    chk("t5 busy after reset", 32'(bus.busy), 0);
    chk("t5 grant_id after reset", 32'(bus.grant_id), 0);
    chk("t5 cl_dataR after reset", 32'(bus.cl_dataR), 0);
    reset = 1'b0;
    wait_idle(60);
`ifdef ARB_TIMEOUT_EN
    // server never answers: ack and timeout_err after 16 REQ cycles, cl_dataR forced to 0
    srv_lat = 1000;
    set_client(0, 4'h5, 1'b1, 8'h00);
    cmd_q.push_back('{0, 4'h5, 1'b1, 8'h00, 16});
    ack_q.push_back('{0, 8'h00, 0, 1'b1});
    issued[0]++;
    wait_idle(60);
    srv_lat = 1;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
